// File: rtl/isi_ctrl_pkg.sv
// Shared types and width helpers for the ISI channel sequencing controller.
package isi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Width of one coefficient word: {mantissa, shift}, each 2*res bits.
  function automatic int coef_width(input int res);
    return 4 * res;
  endfunction

  // Width of a counter that must hold values 0..len inclusive.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/isi_discard_tracker.sv
// Output mask for the channel: drops the channel samples produced by flush
// symbols and registers the surviving samples onto out_data/out_valid.
module isi_discard_tracker
  import isi_ctrl_pkg::*;
#(
  parameter int LEN = 5,
  parameter int RES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [cnt_width(LEN)-1:0] load_val,
  input  logic [RES-1:0]           chan_out,
  input  logic                     chan_out_valid,
  output logic [RES-1:0]           out_data,
  output logic                     out_valid
);

  localparam int CNW = cnt_width(LEN);

  logic [CNW-1:0] discard_q, discard_d;
  logic [RES-1:0] out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;

  // A reload wins over a coincident channel sample; that sample is dropped.
  always_comb begin
    discard_d   = discard_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (load) begin
      discard_d = load_val;
    end else if (chan_out_valid) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CNW'(1);
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = chan_out;
      end
    end
  end

  // Discard counter and output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      discard_q   <= discard_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/isi_channel_ctrl.sv
// Sequencing controller for the parallel ISI channel model: loads taps into
// the coefficient store, flushes the accumulator chain with zero symbols,
// then gates the symbol stream. Optional statistics counters are built when
// ISI_CHAN_CTRL_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a tap write or a run request
// LOAD  | accepting tap writes until cfg_last
// FLUSH | driving PULSE_RESPONSE_LENGTH zero symbols into the channel
// RUN   | forwarding source symbols while enable is high
module isi_channel_ctrl
  import isi_ctrl_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int AW                    = $clog2(PULSE_RESPONSE_LENGTH)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [AW-1:0]                           cfg_addr,
  input  logic [2*SIGNAL_RESOLUTION-1:0]          cfg_mant,
  input  logic [2*SIGNAL_RESOLUTION-1:0]          cfg_shift,
  input  logic                                    cfg_last,
  output logic                                    cfg_err,
  input  logic [SIGNAL_RESOLUTION-1:0]            src_data,
  input  logic                                    src_valid,
  output logic                                    src_ready,
  output logic                                    coef_we,
  output logic [AW-1:0]                           coef_addr,
  output logic [coef_width(SIGNAL_RESOLUTION)-1:0] coef_data,
  output logic [SIGNAL_RESOLUTION-1:0]            chan_in,
  output logic                                    chan_in_valid,
  input  logic [SIGNAL_RESOLUTION-1:0]            chan_out,
  input  logic                                    chan_out_valid,
  output logic [SIGNAL_RESOLUTION-1:0]            out_data,
  output logic                                    out_valid,
`ifdef ISI_CHAN_CTRL_STATS_EN
  output logic [31:0]                             sym_count,
  output logic [15:0]                             flush_count,
`endif
  output logic                                    busy
);

  localparam int             CW       = coef_width(SIGNAL_RESOLUTION);
  localparam int             CNW      = cnt_width(PULSE_RESPONSE_LENGTH);
  localparam logic [CNW-1:0] LEN_C    = CNW'(PULSE_RESPONSE_LENGTH);
  localparam logic [31:0]    ADDR_LIM = 32'(PULSE_RESPONSE_LENGTH);

  state_t                        state_q, state_d;
  logic                          loaded_q, loaded_d;
  logic [CNW-1:0]                flush_cnt_q, flush_cnt_d;
  logic                          cfg_ready_q, cfg_ready_d;
  logic                          busy_q, busy_d;
  logic                          cfg_err_q, cfg_err_d;
  logic                          coef_we_q, coef_we_d;
  logic [AW-1:0]                 coef_addr_q, coef_addr_d;
  logic [CW-1:0]                 coef_data_q, coef_data_d;
  logic [SIGNAL_RESOLUTION-1:0]  chan_in_q, chan_in_d;
  logic                          chan_in_valid_q, chan_in_valid_d;
  logic                          flush_enter;
  logic                          flush_last;
  logic                          cfg_hs, src_hs, addr_oor;

  assign src_ready  = (state_q == RUN) && enable;
  assign cfg_hs     = cfg_valid && cfg_ready_q;
  assign src_hs     = src_valid && src_ready;
  assign addr_oor   = 32'(cfg_addr) >= ADDR_LIM;
  assign flush_last = (state_q == FLUSH) && (flush_cnt_q <= CNW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a cfg handshake in IDLE takes priority over enable.
  always_comb begin
    state_d     = state_q;
    flush_enter = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_hs) begin
          state_d     = cfg_last ? FLUSH : LOAD;
          flush_enter = cfg_last;
        end else if (enable && loaded_q) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (cfg_hs && cfg_last) begin
          state_d     = FLUSH;
          flush_enter = 1'b1;
        end
      end
      FLUSH:   if (flush_last) state_d = enable ? RUN : IDLE;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; handshake-facing flags follow state_d so
  // they line up with the registered state.
  always_comb begin
    cfg_ready_d     = (state_d == IDLE) || (state_d == LOAD);
    busy_d          = (state_d == LOAD) || (state_d == FLUSH);
    coef_we_d       = cfg_hs && !addr_oor;
    coef_addr_d     = coef_addr_q;
    coef_data_d     = coef_data_q;
    cfg_err_d       = cfg_err_q;
    flush_cnt_d     = flush_cnt_q;
    loaded_d        = loaded_q || flush_last;
    chan_in_d       = chan_in_q;
    chan_in_valid_d = 1'b0;
    if (cfg_hs && !addr_oor) begin
      coef_addr_d = cfg_addr;
      coef_data_d = {cfg_mant, cfg_shift};
    end
    if (cfg_hs && (state_q == IDLE) && !cfg_last) cfg_err_d = 1'b0;
    if (cfg_hs && addr_oor)                       cfg_err_d = 1'b1;
    if (flush_enter) begin
      flush_cnt_d = LEN_C;
    end else if ((state_q == FLUSH) && (flush_cnt_q != '0)) begin
      flush_cnt_d = flush_cnt_q - CNW'(1);
    end
    if (state_d == FLUSH) begin
      chan_in_d       = '0;
      chan_in_valid_d = 1'b1;
    end else if (src_hs) begin
      chan_in_d       = src_data;
      chan_in_valid_d = 1'b1;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded_q        <= 1'b0;
      flush_cnt_q     <= '0;
      cfg_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
      coef_we_q       <= 1'b0;
      coef_addr_q     <= '0;
      coef_data_q     <= '0;
      chan_in_q       <= '0;
      chan_in_valid_q <= 1'b0;
    end else begin
      loaded_q        <= loaded_d;
      flush_cnt_q     <= flush_cnt_d;
      cfg_ready_q     <= cfg_ready_d;
      busy_q          <= busy_d;
      cfg_err_q       <= cfg_err_d;
      coef_we_q       <= coef_we_d;
      coef_addr_q     <= coef_addr_d;
      coef_data_q     <= coef_data_d;
      chan_in_q       <= chan_in_d;
      chan_in_valid_q <= chan_in_valid_d;
    end
  end

  isi_discard_tracker #(
    .LEN (PULSE_RESPONSE_LENGTH),
    .RES (SIGNAL_RESOLUTION)
  ) u_discard (
    .clk            (clk),
    .rst            (rst),
    .load           (flush_enter),
    .load_val       (LEN_C),
    .chan_out       (chan_out),
    .chan_out_valid (chan_out_valid),
    .out_data       (out_data),
    .out_valid      (out_valid)
  );

`ifdef ISI_CHAN_CTRL_STATS_EN
  logic [31:0] sym_count_q, sym_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Sample counter wraps; flush counter saturates.
  always_comb begin
    sym_count_d   = sym_count_q + (out_valid ? 32'd1 : 32'd0);
    flush_count_d = flush_count_q;
    if (flush_enter && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_count_q   <= '0;
      flush_count_q <= '0;
    end else begin
      sym_count_q   <= sym_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign sym_count   = sym_count_q;
  assign flush_count = flush_count_q;
`endif

  assign cfg_ready     = cfg_ready_q;
  assign busy          = busy_q;
  assign cfg_err       = cfg_err_q;
  assign coef_we       = coef_we_q;
  assign coef_addr     = coef_addr_q;
  assign coef_data     = coef_data_q;
  assign chan_in       = chan_in_q;
  assign chan_in_valid = chan_in_valid_q;

endmodule

// File: tb/tb_isi_channel_ctrl.sv
// Directed bench for isi_channel_ctrl with an echo channel model
// (chan_out = chan_in, same cycle).
module tb_isi_channel_ctrl;

  localparam int LEN = 5;
  localparam int RES = 8;
  localparam int AW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_last = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [15:0]     cfg_mant = '0;
  logic [15:0]     cfg_shift = '0;
  logic [RES-1:0]  src_data = '0;
  logic            src_valid = 1'b0;

  logic            cfg_ready, cfg_err, src_ready, coef_we, busy;
  logic [AW-1:0]   coef_addr;
  logic [31:0]     coef_data;
  logic [RES-1:0]  chan_in, chan_out, out_data;
  logic            chan_in_valid, chan_out_valid, out_valid;
`ifdef ISI_CHAN_CTRL_STATS_EN
  logic [31:0]     sym_count;
  logic [15:0]     flush_count;
`endif

  assign chan_out       = chan_in;
  assign chan_out_valid = chan_in_valid;

  isi_channel_ctrl #(
    .PULSE_RESPONSE_LENGTH (LEN),
    .SIGNAL_RESOLUTION     (RES),
    .AW                    (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_addr       (cfg_addr),
    .cfg_mant       (cfg_mant),
    .cfg_shift      (cfg_shift),
    .cfg_last       (cfg_last),
    .cfg_err        (cfg_err),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .chan_in        (chan_in),
    .chan_in_valid  (chan_in_valid),
    .chan_out       (chan_out),
    .chan_out_valid (chan_out_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
`ifdef ISI_CHAN_CTRL_STATS_EN
    .sym_count      (sym_count),
    .flush_count    (flush_count),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0]    tap_m [5] = '{16'd127, 16'hFFE0, 16'd16, 16'hFFFC, 16'd8};
  logic [15:0]    tap_s [5] = '{16'd0,   16'd1,    16'd0,  16'd3,    16'd2};
  logic [RES-1:0] sym   [9] = '{8'd48, 8'hF0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Outputs while reset is held.
    #2;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_coef", {coef_we, coef_addr, coef_data[27:0]}, 32'd0);
    chk("rst_chan_in", {23'd0, chan_in_valid, chan_in}, 32'd0);
    chk("rst_out", {23'd0, out_valid, out_data}, 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    step();
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Tap load, back-to-back; enable is high throughout and ignored in LOAD.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_addr  = AW'(i);
      cfg_mant  = tap_m[i];
      cfg_shift = tap_s[i];
      cfg_last  = (i == 4);
      step();
      chk("load_we", 32'(coef_we), 32'd1);
      chk("load_addr", 32'(coef_addr), 32'(i));
      chk("load_data", coef_data, {tap_m[i], tap_s[i]});
      chk("load_busy", 32'(busy), 32'd1);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    chk("flush_cfg_ready", 32'(cfg_ready), 32'd0);

    // Exactly LEN zero symbols, all channel outputs masked.
    for (int k = 0; k < 5; k++) begin
      chk("flush_valid", 32'(chan_in_valid), 32'd1);
      chk("flush_zero", 32'(chan_in), 32'd0);
      chk("flush_busy", 32'(busy), 32'd1);
      chk("flush_mask", 32'(out_valid), 32'd0);
      step();
    end
    chk("post_flush_valid", 32'(chan_in_valid), 32'd0);
    chk("post_flush_mask", 32'(out_valid), 32'd0);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_src_ready", 32'(src_ready), 32'd1);
    chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("run_coef_we", 32'(coef_we), 32'd0);

    // Symbol stream through the echo channel.
    for (int i = 0; i < 9; i++) begin
      src_valid = 1'b1;
      src_data  = sym[i];
      step();
      chk("sym_chan_in", 32'(chan_in), 32'(sym[i]));
      chk("sym_chan_valid", 32'(chan_in_valid), 32'd1);
      if (i == 0) begin
        chk("sym_out_first", 32'(out_valid), 32'd0);
      end else begin
        chk("sym_out_valid", 32'(out_valid), 32'd1);
        chk("sym_out_data", 32'(out_data), 32'(sym[i-1]));
      end
    end
    src_valid = 1'b0;
    step();
    chk("sym_out_last_v", 32'(out_valid), 32'd1);
    chk("sym_out_last_d", 32'(out_data), 32'(sym[8]));
    chk("sym_idle_valid", 32'(chan_in_valid), 32'd0);
    step();
    chk("sym_out_done", 32'(out_valid), 32'd0);

    // Drop enable while a source beat is still offered; cfg held off in RUN.
    src_valid = 1'b1;
    src_data  = 8'd100;
    chk("drop_src_ready_hi", 32'(src_ready), 32'd1);
    step();
    enable    = 1'b0;
    src_data  = 8'd101;
    cfg_valid = 1'b1;
    cfg_addr  = 3'd7;
    cfg_mant  = 16'h1234;
    cfg_shift = 16'h0005;
    #1;
    chk("drop_src_ready_lo", 32'(src_ready), 32'd0);
    chk("drop_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("drop_last_beat", 32'(chan_in), 32'd100);
    step();
    chk("drop_hold", 32'(chan_in), 32'd100);
    chk("drop_no_beat", 32'(chan_in_valid), 32'd0);
    chk("drop_out_v", 32'(out_valid), 32'd1);
    chk("drop_out_d", 32'(out_data), 32'd100);
    chk("drop_idle_src", 32'(src_ready), 32'd0);
    chk("drop_idle_cfg", 32'(cfg_ready), 32'd1);
    src_valid = 1'b0;

    // Out-of-range writes: suppressed, sticky error, last still commits.
    step();
    chk("oor_we", 32'(coef_we), 32'd0);
    chk("oor_err", 32'(cfg_err), 32'd1);
    chk("oor_busy", 32'(busy), 32'd1);
    cfg_last = 1'b1;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    chk("oor_last_we", 32'(coef_we), 32'd0);
    chk("oor_last_data", coef_data, {tap_m[4], tap_s[4]});
    chk("oor_flush", 32'(chan_in_valid), 32'd1);
`ifdef ISI_CHAN_CTRL_STATS_EN
    chk("stats_flush", 32'(flush_count), 32'd2);
    chk("stats_sym", sym_count, 32'd10);
`endif
    for (int k = 0; k < 5; k++) begin
      chk("oor_flush_mask", 32'(out_valid), 32'd0);
      step();
    end
    chk("oor_idle_busy", 32'(busy), 32'd0);
    chk("oor_idle_cfg", 32'(cfg_ready), 32'd1);
    chk("oor_idle_valid", 32'(chan_in_valid), 32'd0);
    chk("oor_err_sticky", 32'(cfg_err), 32'd1);

    // Loaded and enabled, but a cfg request in the same cycle wins.
    enable    = 1'b1;
    cfg_valid = 1'b1;
    cfg_addr  = 3'd2;
    cfg_mant  = tap_m[2];
    cfg_shift = tap_s[2];
    step();
    chk("win_err_clr", 32'(cfg_err), 32'd0);
    chk("win_we", 32'(coef_we), 32'd1);
    chk("win_addr", 32'(coef_addr), 32'd2);
    chk("win_busy", 32'(busy), 32'd1);
    chk("win_src_ready", 32'(src_ready), 32'd0);

    // Reset during flush cycle 3.
    cfg_addr  = 3'd3;
    cfg_mant  = tap_m[3];
    cfg_shift = tap_s[3];
    cfg_last  = 1'b1;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    step();
    step();
    chk("pre_rst_flush", 32'(chan_in_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_chan", {23'd0, chan_in_valid, chan_in}, 32'd0);
    chk("mid_rst_ctl", {28'd0, busy, cfg_ready, src_ready, coef_we}, 32'd0);
    chk("mid_rst_out", {23'd0, out_valid, out_data}, 32'd0);
`ifdef ISI_CHAN_CTRL_STATS_EN
    chk("mid_rst_stats", sym_count | 32'(flush_count), 32'd0);
`endif
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_src", 32'(src_ready), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_valid", 32'(chan_in_valid), 32'd0);
    end
    chk("post_rst_cfg", 32'(cfg_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
